wb_io_arbiter: RTL and testbench
================================

# wb_io_arbiter

Two-master Wishbone arbiter for the SoC IO bus (`wb_m2s_io_*` / `wb_s2m_io_*`).
- It shares the single IO slave port (UART, GPIO/SPI1 peripherals) between the rv32i core data master (m0) and a test/debug master (m1).
- Arbitration is round-robin with a grant locked for a whole `cyc` tenure.
- A bus watchdog terminates stalled cycles with `err`, so neither master can hang the IO bus.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (`sel` is DW/8 bits)
- `TIMEOUT`, 255, max cycles a strobed access may wait for ack/err. 0 disables the watchdog. Range 0..1023.

Ports:
- `clock` in 1: single clock, all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `m0_adr_i` in AW, `m0_dat_i` in DW, `m0_sel_i` in DW/8, `m0_we_i` in 1, `m0_cyc_i` in 1, `m0_stb_i` in 1: core master request.
- `m0_dat_o` out DW, `m0_ack_o` out 1, `m0_err_o` out 1: core master response.
- `m1_*`: identical set for the test/debug master.
- `s_adr_o` out AW, `s_dat_o` out DW, `s_sel_o` out DW/8, `s_we_o` out 1, `s_cyc_o` out 1, `s_stb_o` out 1: to the IO slave.
- `s_dat_i` in DW, `s_ack_i` in 1, `s_err_i` in 1: from the IO slave.
- `grant_o` out 2: one-hot current owner (registered). 00 = idle.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- States: IDLE, OWN0, OWN1. Registers:
  - state
  - priority pointer `last` (the master granted most recently; reset = 1, so m0 wins the first tie)
  - watchdog counter (10 bits)
- IDLE:
  - Only m0_cyc high -> OWN0. Only m1_cyc high -> OWN1.
  - Both high -> the master that is not `last` is granted.
  - Neither high -> stay in IDLE.
- OWNx:
  - Slave request outputs are taken combinationally from master x. `s_cyc_o` = mx_cyc, `s_stb_o` = mx_stb.
  - `mx_ack_o`/`mx_err_o`/`mx_dat_o` are taken from the slave.
  - Master x drops cyc -> IDLE, and `last` := x.
  - Grant is never preempted while the owner holds cyc, including across multiple stb beats.
- Non-granted master: `ack_o` = `err_o` = 0. `dat_o` = `s_dat_i` (don't-care). Its request is held pending; it is not dropped.
- In IDLE: `s_cyc_o` = `s_stb_o` = `s_we_o` = 0. `s_adr_o`/`s_dat_o`/`s_sel_o` are driven from m0 (don't-care).
- Watchdog:
  - Clears when not in OWNx, when owner stb = 0, or when `s_ack_i | s_err_i`.
  - Otherwise it increments while owner stb is high.
  - When the count equals TIMEOUT, that cycle:
    - assert `mx_err_o`
    - force `s_stb_o` = `s_cyc_o` = 0
    - pulse `timeout_o`
    - clear the counter
  - The state stays OWNx until the master drops cyc.
  - A slave ack in the same cycle as the timeout takes priority: normal ack, no err, no pulse.
- `s_err_i` passes through to the owner unchanged.

## Timing
- Reset values:
  - state IDLE, `grant_o` = 00, `last` = 1, counter 0, `timeout_o` 0
  - all `s_*` request outputs 0
  - all master ack/err 0
- Arbitration latency: cyc seen in IDLE at edge N -> OWNx from edge N+1. The slave sees cyc/stb in cycle N+1, one cycle of added latency.
- The data path is combinational in OWNx; ack and data pass through with zero added latency.
- Release: owner cyc low during cycle N -> IDLE after edge N+1. A pending other master is granted after edge N+2. There is one idle gap cycle between tenures.
- Reset mid-cycle: everything returns to reset values immediately (async). Any in-flight access is abandoned with no ack.
- With TIMEOUT = T, err is asserted in the (T+1)th consecutive stalled stb cycle after grant.

## Test plan
- Single m0 read, adr 0x2000_0000, slave acks 1 cycle after stb:
  - grant_o = 01 one cycle after cyc
  - m0_ack_o is high for exactly one cycle with `s_dat_i` = 0xDEAD_BEEF
  - m1 sees no ack
- Both masters raise cyc in the same cycle after reset:
  - m0 is granted first
  - after m0 drops cyc, one idle cycle, then grant_o = 10
  - a second simultaneous request is then granted to m0 (round-robin alternation)
- m1 holds cyc across 3 stb beats while m0 requests:
  - grant_o stays 10 for all 3 beats
  - m0_ack_o stays 0
  - m0 is granted only after m1 releases
- TIMEOUT = 8, slave never acks:
  - m0_err_o and timeout_o are high for exactly one cycle, 9 stalled cycles after stb
  - `s_stb_o` is low that cycle
  - grant is retained until m0 drops cyc
- Slave ack on exactly the timeout cycle: ack is delivered, with no err and no timeout_o pulse.
- reset_n pulled low mid-transfer while OWN1:
  - all outputs are immediately at reset values
  - after release, an m0 request is granted normally

Source files
------------

// File: rtl/wb_io_arbiter.sv
// Two-master Wishbone arbiter for the SoC IO bus: round-robin grant held for a whole
// cyc tenure, plus a watchdog that ends stalled strobes with err.
module wb_io_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT);

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [9:0] wd_cnt, wd_cnt_nxt;
  logic       own_cyc, own_stb, wd_fire;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      last   <= 1'b1;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      last   <= last_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

  // On a tie the master that was not granted last wins.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last)) state_nxt = OWN0;
        else if (m1_cyc_i)                    state_nxt = OWN1;
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          state_nxt = IDLE;
          last_nxt  = 1'b0;
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          state_nxt = IDLE;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    case (state)
      OWN0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
      end
      OWN1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
      end
      default: ;
    endcase
  end

  // A slave response in the timeout cycle wins over the watchdog.
  assign wd_fire = (TIMEOUT != 0) && own_cyc && own_stb && !(s_ack_i || s_err_i)
                   && (wd_cnt == WD_LIMIT);

  always_comb begin
    if ((TIMEOUT == 0) || !own_cyc || !own_stb || s_ack_i || s_err_i || wd_fire)
      wd_cnt_nxt = '0;
    else
      wd_cnt_nxt = wd_cnt + 10'd1;
  end

  assign timeout_o = wd_fire;
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;

  always_comb begin
    s_adr_o  = m0_adr_i;
    s_dat_o  = m0_dat_i;
    s_sel_o  = m0_sel_i;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    grant_o  = 2'b00;
    case (state)
      OWN0: begin
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i & ~wd_fire;
        s_stb_o  = m0_stb_i & ~wd_fire;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | wd_fire;
        grant_o  = 2'b01;
      end
      OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i & ~wd_fire;
        s_stb_o  = m1_stb_i & ~wd_fire;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | wd_fire;
        grant_o  = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Scenario bench for wb_io_arbiter: a small slave model with programmable ack delay and
// a queue of expected read data checked whenever a master sees ack.
module tb_wb_io_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int T  = 8;

  typedef struct {
    int          m;
    logic [31:0] d;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [AW-1:0] m0_adr, m1_adr, s_adr;
  logic [DW-1:0] m0_wdat, m1_wdat, m0_rdat, m1_rdat, s_wdat;
  logic [3:0]    m0_sel, m1_sel, s_sel;
  logic          m0_we, m0_cyc, m0_stb, m0_ack, m0_err;
  logic          m1_we, m1_cyc, m1_stb, m1_ack, m1_err;
  logic          s_we, s_cyc, s_stb;
  logic [DW-1:0] slv_data;
  logic          s_ack, s_err;
  logic [1:0]    grant;
  logic          tmo;

  int   n_checks, n_fail;
  int   ack_delay;
  int   slv_cnt;
  exp_t exp_q[$];

  wb_io_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(T)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_wdat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb),
    .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_wdat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb),
    .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_dat_i(slv_data), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant), .timeout_o(tmo)
  );

  always #5 clock = ~clock;

  // Slave acks in the cycle after ack_delay stalled strobe cycles; 0 means never.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slv_cnt <= 0;
      s_ack   <= 1'b0;
    end else if (s_cyc && s_stb && !s_ack) begin
      slv_cnt <= slv_cnt + 1;
      s_ack   <= (ack_delay != 0) && (slv_cnt + 1 == ack_delay);
    end else begin
      slv_cnt <= 0;
      s_ack   <= 1'b0;
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_masters();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL rst_grant: got %b expected 00", grant);
    end
    n_checks++;
    if ({s_cyc, s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err, tmo} !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_outputs: got %b expected 00000000",
               {s_cyc, s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err, tmo});
    end
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (grant !== 2'b00 || s_cyc !== 1'b0) begin
      n_fail++; $display("FAIL rst_idle: got grant %b cyc %b expected 00 0", grant, s_cyc);
    end
  endtask

  task automatic test_single_read();
    int   acks = 0, m1_acks = 0;
    exp_t e;
    ack_delay = 1;
    next_cycle();
    m0_adr = 32'h2000_0000; m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0;
    slv_data = 32'hDEAD_BEEF;
    exp_q.push_back('{m: 0, d: 32'hDEAD_BEEF});
    @(negedge clock);
    n_checks++;
    if (grant !== 2'b00 || s_cyc !== 1'b0) begin
      n_fail++; $display("FAIL sr_latency: got grant %b cyc %b expected 00 0", grant, s_cyc);
    end
    next_cycle();
    @(negedge clock);
    n_checks++;
    if (grant !== 2'b01 || s_stb !== 1'b1 || s_adr !== 32'h2000_0000) begin
      n_fail++;
      $display("FAIL sr_grant: got grant %b stb %b adr %h expected 01 1 20000000", grant, s_stb, s_adr);
    end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      if (m1_ack || m1_err) m1_acks++;
      if (m0_ack) begin
        acks++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sr_sb_empty: got m0 ack %h expected none", m0_rdat);
        end else begin
          e = exp_q.pop_front();
          if (e.m != 0 || m0_rdat !== e.d) begin
            n_fail++; $display("FAIL sr_data: got m0 %h expected m%0d %h", m0_rdat, e.m, e.d);
          end
        end
      end
      next_cycle();
      if (acks > 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
    end
    n_checks++;
    if (acks != 1) begin
      n_fail++; $display("FAIL sr_ack_count: got %0d expected 1", acks);
    end
    n_checks++;
    if (m1_acks != 0) begin
      n_fail++; $display("FAIL sr_m1_ack: got %0d expected 0", m1_acks);
    end
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   got;
    test_reset();
    ack_delay = 1;
    next_cycle();
    m0_adr = 32'h2000_0100; m0_cyc = 1'b1; m0_stb = 1'b1;
    m1_adr = 32'h3000_0200; m1_cyc = 1'b1; m1_stb = 1'b1;
    slv_data = 32'hA0A0_0001;
    exp_q.push_back('{m: 0, d: 32'hA0A0_0001});
    next_cycle();
    @(negedge clock);
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL rr_first: got %b expected 01", grant);
    end
    for (int r = 0; r < 3; r++) begin
      got = 0;
      for (int i = 0; i < 8 && got == 0; i++) begin
        if (i > 0) @(negedge clock);
        if ((r != 1 && m0_ack) || (r == 1 && m1_ack)) begin
          got = 1;
          n_checks++;
          e = exp_q.pop_front();
          if (e.m != (r == 1 ? 1 : 0) || (r == 1 ? m1_rdat : m0_rdat) !== e.d) begin
            n_fail++;
            $display("FAIL rr_data%0d: got %h expected m%0d %h", r, r == 1 ? m1_rdat : m0_rdat, e.m, e.d);
          end
        end
        next_cycle();
      end
      if (got == 0) begin
        n_checks++; n_fail++; $display("FAIL rr_ack_wait%0d: got no ack expected ack", r);
      end
      if (r == 0) begin
        m0_cyc = 1'b0; m0_stb = 1'b0;
        @(negedge clock);
        next_cycle();
        @(negedge clock);
        n_checks++;
        if (grant !== 2'b00) begin
          n_fail++; $display("FAIL rr_gap: got %b expected 00", grant);
        end
        slv_data = 32'hB1B1_0002;
        exp_q.push_back('{m: 1, d: 32'hB1B1_0002});
        next_cycle();
        @(negedge clock);
        n_checks++;
        if (grant !== 2'b10) begin
          n_fail++; $display("FAIL rr_second: got %b expected 10", grant);
        end
      end else if (r == 1) begin
        m1_cyc = 1'b0; m1_stb = 1'b0;
        next_cycle();
        next_cycle();
        m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
        slv_data = 32'hC2C2_0003;
        exp_q.push_back('{m: 0, d: 32'hC2C2_0003});
        next_cycle();
        @(negedge clock);
        n_checks++;
        if (grant !== 2'b01) begin
          n_fail++; $display("FAIL rr_third: got %b expected 01", grant);
        end
      end else begin
        idle_masters();
      end
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_lock();
    exp_t e;
    int   got, bad_grant = 0, m0_resp = 0;
    ack_delay = 1;
    next_cycle();
    m1_adr = 32'h3000_0010; m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    next_cycle();
    @(negedge clock);
    n_checks++;
    if (grant !== 2'b10) begin
      n_fail++; $display("FAIL lk_grant: got %b expected 10", grant);
    end
    next_cycle();
    m0_adr = 32'h2000_0040; m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int b = 0; b < 3; b++) begin
      slv_data = 32'h1111_0000 + 32'(b);
      exp_q.push_back('{m: 1, d: 32'h1111_0000 + 32'(b)});
      got = 0;
      for (int i = 0; i < 8 && got == 0; i++) begin
        @(negedge clock);
        if (grant !== 2'b10) bad_grant++;
        if (m0_ack || m0_err) m0_resp++;
        if (m1_ack) begin
          got = 1;
          n_checks++;
          e = exp_q.pop_front();
          if (e.m != 1 || m1_rdat !== e.d) begin
            n_fail++; $display("FAIL lk_data%0d: got %h expected m%0d %h", b, m1_rdat, e.m, e.d);
          end
        end
        next_cycle();
      end
      if (got == 0) begin
        n_checks++; n_fail++; $display("FAIL lk_ack_wait%0d: got no ack expected ack", b);
      end
    end
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    @(negedge clock);
    if (grant !== 2'b10) bad_grant++;
    n_checks++;
    if (bad_grant != 0) begin
      n_fail++; $display("FAIL lk_held: got %0d cycles off 10 expected 0", bad_grant);
    end
    n_checks++;
    if (m0_resp != 0) begin
      n_fail++; $display("FAIL lk_m0_ack: got %0d expected 0", m0_resp);
    end
    next_cycle();
    @(negedge clock);
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL lk_gap: got %b expected 00", grant);
    end
    slv_data = 32'h2222_0000;
    exp_q.push_back('{m: 0, d: 32'h2222_0000});
    next_cycle();
    @(negedge clock);
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL lk_m0_grant: got %b expected 01", grant);
    end
    got = 0;
    for (int i = 0; i < 8 && got == 0; i++) begin
      if (i > 0) @(negedge clock);
      if (m0_ack) begin
        got = 1;
        n_checks++;
        e = exp_q.pop_front();
        if (e.m != 0 || m0_rdat !== e.d) begin
          n_fail++; $display("FAIL lk_m0_data: got %h expected m%0d %h", m0_rdat, e.m, e.d);
        end
      end
      next_cycle();
    end
    if (got == 0) begin
      n_checks++; n_fail++; $display("FAIL lk_m0_wait: got no ack expected ack");
    end
    idle_masters();
    repeat (2) next_cycle();
  endtask

  task automatic test_timeout();
    int err_cnt = 0, err_at = 0, tmo_cnt = 0, bad_grant = 0;
    logic stb_at_err = 1'b1;
    ack_delay = 0;
    next_cycle();
    m0_adr = 32'h2000_0080; m0_cyc = 1'b1; m0_stb = 1'b1;
    next_cycle();
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock);
      if (grant !== 2'b01) bad_grant++;
      if (tmo) tmo_cnt++;
      if (m0_err) begin
        err_cnt++;
        err_at = i;
        stb_at_err = s_stb;
      end
      next_cycle();
      if (err_cnt > 0) m0_stb = 1'b0;
    end
    n_checks++;
    if (err_cnt != 1 || err_at != T + 1) begin
      n_fail++; $display("FAIL to_err: got %0d errs at cycle %0d expected 1 at %0d", err_cnt, err_at, T + 1);
    end
    n_checks++;
    if (tmo_cnt != 1) begin
      n_fail++; $display("FAIL to_pulse: got %0d expected 1", tmo_cnt);
    end
    n_checks++;
    if (stb_at_err !== 1'b0) begin
      n_fail++; $display("FAIL to_stb: got %b expected 0", stb_at_err);
    end
    n_checks++;
    if (bad_grant != 0) begin
      n_fail++; $display("FAIL to_held: got %0d cycles off 01 expected 0", bad_grant);
    end
    m0_cyc = 1'b0;
    next_cycle();
    @(negedge clock);
    n_checks++;
    if (grant !== 2'b00) begin
      n_fail++; $display("FAIL to_release: got %b expected 00", grant);
    end
    repeat (2) next_cycle();
  endtask

  task automatic test_ack_at_timeout();
    exp_t e;
    int   acks = 0, ack_at = 0, errs = 0, tmo_cnt = 0;
    ack_delay = T;
    next_cycle();
    m0_adr = 32'h2000_00C0; m0_cyc = 1'b1; m0_stb = 1'b1;
    slv_data = 32'h5EED_F00D;
    exp_q.push_back('{m: 0, d: 32'h5EED_F00D});
    next_cycle();
    for (int i = 1; i <= 14; i++) begin
      @(negedge clock);
      if (tmo) tmo_cnt++;
      if (m0_err) errs++;
      if (m0_ack) begin
        acks++;
        ack_at = i;
        n_checks++;
        e = exp_q.pop_front();
        if (e.m != 0 || m0_rdat !== e.d) begin
          n_fail++; $display("FAIL ar_data: got %h expected m%0d %h", m0_rdat, e.m, e.d);
        end
      end
      next_cycle();
      if (acks > 0) begin m0_cyc = 1'b0; m0_stb = 1'b0; end
    end
    n_checks++;
    if (acks != 1 || ack_at != T + 1) begin
      n_fail++; $display("FAIL ar_ack: got %0d acks at cycle %0d expected 1 at %0d", acks, ack_at, T + 1);
    end
    n_checks++;
    if (errs != 0 || tmo_cnt != 0) begin
      n_fail++; $display("FAIL ar_no_err: got err %0d timeout %0d expected 0 0", errs, tmo_cnt);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   got = 0;
    ack_delay = 0;
    next_cycle();
    m1_adr = 32'h3000_0400; m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
    next_cycle();
    @(negedge clock);
    n_checks++;
    if (grant !== 2'b10 || s_stb !== 1'b1 || s_we !== 1'b1) begin
      n_fail++; $display("FAIL rm_pre: got grant %b stb %b we %b expected 10 1 1", grant, s_stb, s_we);
    end
    next_cycle();
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== 2'b00 ||
        {s_cyc, s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err, tmo} !== 8'h00) begin
      n_fail++;
      $display("FAIL rm_async: got grant %b outs %b expected 00 00000000", grant,
               {s_cyc, s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err, tmo});
    end
    idle_masters();
    next_cycle();
    reset_n = 1'b1;
    ack_delay = 1;
    next_cycle();
    m0_adr = 32'h2000_0500; m0_cyc = 1'b1; m0_stb = 1'b1;
    slv_data = 32'h0BAD_CAFE;
    exp_q.push_back('{m: 0, d: 32'h0BAD_CAFE});
    next_cycle();
    @(negedge clock);
    n_checks++;
    if (grant !== 2'b01) begin
      n_fail++; $display("FAIL rm_regrant: got %b expected 01", grant);
    end
    for (int i = 0; i < 8 && got == 0; i++) begin
      if (i > 0) @(negedge clock);
      if (m0_ack) begin
        got = 1;
        n_checks++;
        e = exp_q.pop_front();
        if (e.m != 0 || m0_rdat !== e.d) begin
          n_fail++; $display("FAIL rm_data: got %h expected m%0d %h", m0_rdat, e.m, e.d);
        end
      end
      next_cycle();
    end
    if (got == 0) begin
      n_checks++; n_fail++; $display("FAIL rm_ack_wait: got no ack expected ack");
    end
    idle_masters();
    repeat (2) next_cycle();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ack_delay = 1;
    slv_data = '0;
    s_err = 1'b0;
    m0_adr = '0; m0_wdat = 32'h0000_00A0; m0_sel = 4'hF;
    m1_adr = '0; m1_wdat = 32'h0000_00B1; m1_sel = 4'hF;
    idle_masters();
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "bench time limit");
  end

endmodule
